// File: rtl/txrx_pkg.sv
// Shared types and constants for the framed character receiver.
// Optional build macro: TXRX_PRINTABLE_FILTER_EN (drops control characters inside a frame).
package txrx_pkg;

  localparam int CHAR_W = 7;
  localparam logic [CHAR_W-1:0] START_CHAR = 7'h00;
  localparam logic [CHAR_W-1:0] STOP_CHAR  = 7'h7F;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // True for control characters that the printable filter removes (LF and CR are kept).
  function automatic logic is_filtered_ctrl(input logic [CHAR_W-1:0] c);
    return (c >= 7'h01) && (c <= 7'h1F) && (c != 7'h0A) && (c != 7'h0D);
  endfunction

endpackage

// File: rtl/txrx_if.sv
// Character bus: CPU-side tx input plus the valid/ready output stream.
interface txrx_if;
  logic [txrx_pkg::CHAR_W-1:0] tx;
  logic [txrx_pkg::CHAR_W-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (output tx, output out_ready, input out_data, input out_valid);
  modport slave  (input tx, input out_ready, output out_data, output out_valid);
endinterface

// File: rtl/txrx_fifo.sv
// Synchronous FIFO with a registered head word; pointers carry an extra wrap bit
// so full and empty can be told apart.
module txrx_fifo
  import txrx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = CHAR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  // Read pointer after this edge's pop, used to pick the next head word.
  always_comb begin
    rd_next = rd_ptr;
    if (do_pop) begin
      rd_next = rd_ptr + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_next = rd_ptr;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (do_push) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr <= wr_ptr;
      end
    end
  end

  // Head register: next stored entry, else the word pushed into an empty FIFO, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_next != wr_ptr) begin
      rdata <= mem[rd_next[AW-1:0]];
    end else if (do_push) begin
      rdata <= wdata;
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/tx_frame_rx.sv
// Framed character receiver: start/stop marker FSM, character counter and
// sticky overflow around a txrx_fifo buffer.
// Optional build macro: TXRX_PRINTABLE_FILTER_EN.
module tx_frame_rx
  import txrx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  txrx_if.slave            bus,
  output logic             frame_active,
  output logic             frame_done,
  output logic             overflow,
  output logic [CNT_W-1:0] char_count
);

  state_t state_q;
  state_t state_d;
  logic   push_req;
  logic   push_ok;
  logic   done_d;
  logic   clear_cnt;
  logic   is_char;
  logic   fifo_full;
  logic   fifo_empty;

`ifdef TXRX_PRINTABLE_FILTER_EN
  assign is_char = !is_filtered_ctrl(bus.tx);
`else
  assign is_char = 1'b1;
`endif

  // Next state and per-cycle control decode.
  always_comb begin
    state_d   = state_q;
    push_req  = 1'b0;
    done_d    = 1'b0;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tx == START_CHAR) begin
          state_d   = ACTIVE;
          clear_cnt = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (bus.tx == STOP_CHAR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (bus.tx == START_CHAR) begin
          state_d = ACTIVE;
        end else begin
          push_req = is_char;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Full FIFO still takes the character when the consumer pops this cycle.
  assign push_ok = push_req && (!fifo_full || bus.out_ready);

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_active <= (state_d == ACTIVE);
      frame_done   <= done_d;
      overflow     <= overflow || (push_req && !push_ok);
    end
  end

  // Accepted-character counter: cleared on start marker, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      char_count <= '0;
    end else if (clear_cnt) begin
      char_count <= '0;
    end else if (push_ok && (char_count != {CNT_W{1'b1}})) begin
      char_count <= char_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      char_count <= char_count;
    end
  end

  txrx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CHAR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .wdata (bus.tx),
    .pop   (bus.out_ready),
    .rdata (bus.out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;

endmodule

// File: tb/tb_tx_frame_rx.sv
// Self-checking bench for tx_frame_rx: cycle model + scoreboard queue,
// a vector table for the basic frame and directed corner-case sequences.
module tb_tx_frame_rx;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             frame_active;
  logic             frame_done;
  logic             overflow;
  logic [CNT_W-1:0] char_count;

  txrx_if bus ();

  tx_frame_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .char_count   (char_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  logic [6:0] q[$];
  bit         m_st;
  bit         m_done;
  bit         m_ovf;
  int         m_cnt;
  logic [6:0] m_data;

  typedef struct {
    logic [6:0] tx;
    logic       rdy;
    logic       exp_valid;
    logic [6:0] exp_data;
    logic       exp_active;
    logic       exp_done;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[5];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit filt(logic [6:0] c);
`ifdef TXRX_PRINTABLE_FILTER_EN
    return (c >= 7'h01) && (c <= 7'h1F) && (c != 7'h0A) && (c != 7'h0D);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs(string tag);
    chk({tag, "_valid"},  32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, "_data"},   32'(bus.out_data),  32'(m_data));
    chk({tag, "_active"}, 32'(frame_active),  32'(m_st));
    chk({tag, "_done"},   32'(frame_done),    32'(m_done));
    chk({tag, "_ovf"},    32'(overflow),      32'(m_ovf));
    chk({tag, "_cnt"},    32'(char_count),    32'(m_cnt));
  endtask

  // One clock cycle: drive inputs, update model, compare after the edge.
  task automatic step(input logic [6:0] t, input logic r);
    logic [6:0] exp;
    bit req;
    bus.tx = t;
    bus.out_ready = r;
    if (r && q.size() != 0) begin
      exp = q.pop_front();
      chk("sb_head", 32'(bus.out_data), 32'(exp));
    end
    req = m_st && (t != 7'h00) && (t != 7'h7F) && !filt(t);
    m_done = m_st && (t == 7'h7F);
    if (!m_st && t == 7'h00) begin
      m_st = 1'b1;
      m_cnt = 0;
    end else if (m_st && t == 7'h7F) begin
      m_st = 1'b0;
    end
    if (req) begin
      if (q.size() < DEPTH) begin
        q.push_back(t);
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (q.size() != 0) m_data = q[0];
    check_outputs("step");
  endtask

  // Reset cycle with live tx/out_ready activity that must be ignored.
  task automatic do_reset(input logic [6:0] t);
    reset = 1'b1;
    bus.tx = t;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_st = 1'b0;
    m_done = 1'b0;
    m_ovf = 1'b0;
    m_cnt = 0;
    m_data = 7'h00;
    check_outputs("reset");
  endtask

  initial begin
    reset = 1'b1;
    bus.tx = 7'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(7'h00);

    // Basic frame 00,'H','i',7F then an ignored character in IDLE.
    tbl[0] = '{7'h00, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 0};
    tbl[1] = '{7'h48, 1'b1, 1'b1, 7'h48, 1'b1, 1'b0, 1};
    tbl[2] = '{7'h69, 1'b1, 1'b1, 7'h69, 1'b1, 1'b0, 2};
    tbl[3] = '{7'h7F, 1'b1, 1'b0, 7'h69, 1'b0, 1'b1, 2};
    tbl[4] = '{7'h51, 1'b1, 1'b0, 7'h69, 1'b0, 1'b0, 2};
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].tx, tbl[i].rdy);
      chk("tbl_valid",  32'(bus.out_valid), 32'(tbl[i].exp_valid));
      chk("tbl_data",   32'(bus.out_data),  32'(tbl[i].exp_data));
      chk("tbl_active", 32'(frame_active),  32'(tbl[i].exp_active));
      chk("tbl_done",   32'(frame_done),    32'(tbl[i].exp_done));
      chk("tbl_cnt",    32'(char_count),    32'(tbl[i].exp_cnt));
    end

    // Characters while IDLE are ignored, stop marker in IDLE gives no pulse.
    step(7'h41, 1'b1);
    step(7'h42, 1'b1);
    step(7'h7F, 1'b1);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_done",  32'(frame_done),    32'd0);

    // Overflow: 20 characters into a 16-deep FIFO with no consumer, then drain.
    step(7'h00, 1'b0);
    for (int i = 0; i < 20; i++) step(7'(7'h61 + i), 1'b0);
    chk("ovf_flag", 32'(overflow),   32'd1);
    chk("ovf_cnt",  32'(char_count), 32'd16);
    step(7'h7F, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(7'h01, 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with continuous push and pop: no overflow, order kept.
    do_reset(7'h00);
    step(7'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(7'(7'h30 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(7'(7'h50 + i), 1'b1);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_cnt", 32'(char_count), 32'(DEPTH + 10));
    step(7'h7F, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) step(7'h02, 1'b1);

    // Reset mid-frame, with a stop marker on the reset cycle.
    step(7'h00, 1'b0);
    step(7'h31, 1'b0);
    step(7'h32, 1'b0);
    step(7'h33, 1'b0);
    do_reset(7'h7F);
    chk("rst_done", 32'(frame_done), 32'd0);
    step(7'h00, 1'b0);
    step(7'h5A, 1'b0);
    step(7'h7F, 1'b0);
    chk("z_cnt", 32'(char_count), 32'd1);
    step(7'h04, 1'b1);
    step(7'h04, 1'b1);

    // Control characters inside a frame.
    step(7'h00, 1'b0);
    step(7'h78, 1'b0);
    step(7'h07, 1'b0);
    step(7'h0A, 1'b0);
    step(7'h79, 1'b0);
    step(7'h7F, 1'b0);
`ifdef TXRX_PRINTABLE_FILTER_EN
    chk("filt_cnt", 32'(char_count), 32'd3);
`else
    chk("filt_cnt", 32'(char_count), 32'd4);
`endif
    for (int i = 0; i < 6; i++) step(7'h05, 1'b1);

    // Counter saturation.
    step(7'h00, 1'b1);
    for (int i = 0; i < CMAX + 40; i++) step(7'h63, 1'b1);
    chk("sat_cnt", 32'(char_count), 32'(CMAX));
    step(7'h7F, 1'b1);
    step(7'h06, 1'b1);

    // Random traffic against the model.
    do_reset(7'h00);
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [6:0] t;
      sel = $urandom_range(0, 11);
      if (sel == 0)      t = 7'h00;
      else if (sel == 1) t = 7'h7F;
      else if (sel == 2) t = 7'($urandom_range(1, 31));
      else               t = 7'($urandom_range(32, 126));
      step(t, ($urandom_range(0, 3) != 0));
    end
    step(7'h7F, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) step(7'h41, 1'b1);
    chk("final_empty", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
